udm_bus_decoder: RTL and testbench

- Sits directly downstream of the udm bus master port and routes each master request to one of two slave windows: CSR window S0 and memory window S1.
- Reads to unmapped addresses are completed locally.
- Read responses are returned to the master strictly in issue order, using an outstanding-read tracker.
- Replaces ad-hoc address decoding and response muxing in board top levels.

---
 rtl/udm_bus_decoder.sv | 187 ++++++++++++++++++
 tb/tb_udm_bus_decoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/udm_bus_decoder.sv
// Routes udm master requests to a CSR window (S0), a memory window (S1) or a local
// unmapped responder, and returns read responses in issue order.
module udm_bus_decoder #(
  parameter logic [31:0] S0_BASE         = 32'h0000_0000,
  parameter logic [31:0] S0_SIZE         = 32'h0000_1000,
  parameter logic [31:0] S1_BASE         = 32'h8000_0000,
  parameter logic [31:0] S1_SIZE         = 32'h0000_1000,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter logic [31:0] UNMAPPED_RDATA  = 32'hDEAD_BEEF,
  localparam int unsigned PW = $clog2(MAX_OUTSTANDING),
  localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          m_req_i,
  input  logic          m_we_i,
  input  logic [31:0]   m_addr_bi,
  input  logic [3:0]    m_be_bi,
  input  logic [31:0]   m_wdata_bi,
  output logic          m_ack_o,
  output logic          m_resp_o,
  output logic [31:0]   m_rdata_bo,
  output logic          s0_req_o,
  output logic          s0_we_o,
  output logic [31:0]   s0_addr_bo,
  output logic [3:0]    s0_be_bo,
  output logic [31:0]   s0_wdata_bo,
  input  logic          s0_ack_i,
  input  logic          s0_resp_i,
  input  logic [31:0]   s0_rdata_bi,
  output logic          s1_req_o,
  output logic          s1_we_o,
  output logic [31:0]   s1_addr_bo,
  output logic [3:0]    s1_be_bo,
  output logic [31:0]   s1_wdata_bo,
  input  logic          s1_ack_i,
  input  logic          s1_resp_i,
  input  logic [31:0]   s1_rdata_bi,
  output logic [CW-1:0] outstanding_o,
  output logic          err_o
);

  // Handshake: a request transfers on the cycle req && ack are both high; the
  // requester holds all request fields stable until then. Each accepted read
  // produces exactly one single-cycle resp pulse; writes produce none.

  typedef enum logic [1:0] {
    TGT_S0  = 2'd0,
    TGT_S1  = 2'd1,
    TGT_UNM = 2'd2
  } tgt_e;

  logic [31:0]   s0_off, s1_off;
  tgt_e          tgt;
  logic          is_read, empty, full, stall, push, pop;
  logic          head_resp;
  tgt_e          head;
  logic [31:0]   head_rdata;

  tgt_e          fifo_q [MAX_OUTSTANDING];
  tgt_e          fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  tgt_e          last_tgt_q, last_tgt_d;
  logic          unm_resp_q, unm_resp_d;
  logic          m_resp_q, m_resp_d;
  logic [31:0]   m_rdata_q, m_rdata_d;
  logic          err_q, err_d;

  assign s0_off = m_addr_bi - S0_BASE;
  assign s1_off = m_addr_bi - S1_BASE;

  always_comb begin
    tgt = TGT_UNM;
    if (m_addr_bi >= S0_BASE && s0_off < S0_SIZE) tgt = TGT_S0;
    else if (m_addr_bi >= S1_BASE && s1_off < S1_SIZE) tgt = TGT_S1;
  end

  assign is_read = m_req_i && !m_we_i;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(MAX_OUTSTANDING));
  // A read may only join the tracker behind reads to the same target, so
  // per-slave ordering alone guarantees global in-order return.
  assign stall   = is_read && (full || (!empty && tgt != last_tgt_q));

  assign s0_req_o    = m_req_i && tgt == TGT_S0 && !stall;
  assign s0_we_o     = m_we_i;
  assign s0_addr_bo  = s0_off;
  assign s0_be_bo    = m_be_bi;
  assign s0_wdata_bo = m_wdata_bi;

  assign s1_req_o    = m_req_i && tgt == TGT_S1 && !stall;
  assign s1_we_o     = m_we_i;
  assign s1_addr_bo  = s1_off;
  assign s1_be_bo    = m_be_bi;
  assign s1_wdata_bo = m_wdata_bi;

  always_comb begin
    m_ack_o = 1'b0;
    case (tgt)
      TGT_S0:  m_ack_o = s0_ack_i && s0_req_o;
      TGT_S1:  m_ack_o = s1_ack_i && s1_req_o;
      default: m_ack_o = m_req_i && !stall;
    endcase
  end

  assign push = m_ack_o && !m_we_i;
  assign head = fifo_q[rd_ptr_q];

  always_comb begin
    head_resp  = 1'b0;
    head_rdata = UNMAPPED_RDATA;
    if (!empty) begin
      case (head)
        TGT_S0: begin
          head_resp  = s0_resp_i;
          head_rdata = s0_rdata_bi;
        end
        TGT_S1: begin
          head_resp  = s1_resp_i;
          head_rdata = s1_rdata_bi;
        end
        default: begin
          head_resp  = unm_resp_q;
          head_rdata = UNMAPPED_RDATA;
        end
      endcase
    end
  end

  assign pop = head_resp;

  always_comb begin
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_tgt_d = last_tgt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = tgt;
      wr_ptr_d         = wr_ptr_q + PW'(1);
      last_tgt_d       = tgt;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    unm_resp_d = push && tgt == TGT_UNM;
    m_resp_d   = head_resp;
    m_rdata_d  = head_resp ? head_rdata : m_rdata_q;
    err_d      = err_q;
    // Responses nobody is waiting for are dropped and latched as an error.
    if (s0_resp_i && (empty || head != TGT_S0)) err_d = 1'b1;
    if (s1_resp_i && (empty || head != TGT_S1)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) fifo_q[i] <= TGT_S0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_tgt_q <= TGT_S0;
      unm_resp_q <= 1'b0;
      m_resp_q   <= 1'b0;
      m_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_tgt_q <= last_tgt_d;
      unm_resp_q <= unm_resp_d;
      m_resp_q   <= m_resp_d;
      m_rdata_q  <= m_rdata_d;
      err_q      <= err_d;
    end
  end

  assign m_resp_o      = m_resp_q;
  assign m_rdata_bo    = m_rdata_q;
  assign outstanding_o = count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_udm_bus_decoder.sv
// Directed bench for udm_bus_decoder: decode, forwarding, ordering stalls,
// tracker depth, error flag and asynchronous reset.
module tb_udm_bus_decoder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_req_i, m_we_i;
  logic [31:0] m_addr_bi, m_wdata_bi;
  logic [3:0]  m_be_bi;
  logic        m_ack_o, m_resp_o;
  logic [31:0] m_rdata_bo;
  logic        s0_req_o, s0_we_o, s1_req_o, s1_we_o;
  logic [31:0] s0_addr_bo, s0_wdata_bo, s1_addr_bo, s1_wdata_bo;
  logic [3:0]  s0_be_bo, s1_be_bo;
  logic        s0_ack_i, s0_resp_i, s1_ack_i, s1_resp_i;
  logic [31:0] s0_rdata_bi, s1_rdata_bi;
  logic [2:0]  outstanding_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  udm_bus_decoder dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_bi(m_addr_bi), .m_be_bi(m_be_bi),
    .m_wdata_bi(m_wdata_bi), .m_ack_o(m_ack_o), .m_resp_o(m_resp_o), .m_rdata_bo(m_rdata_bo),
    .s0_req_o(s0_req_o), .s0_we_o(s0_we_o), .s0_addr_bo(s0_addr_bo), .s0_be_bo(s0_be_bo),
    .s0_wdata_bo(s0_wdata_bo), .s0_ack_i(s0_ack_i), .s0_resp_i(s0_resp_i), .s0_rdata_bi(s0_rdata_bi),
    .s1_req_o(s1_req_o), .s1_we_o(s1_we_o), .s1_addr_bo(s1_addr_bo), .s1_be_bo(s1_be_bo),
    .s1_wdata_bo(s1_wdata_bo), .s1_ack_i(s1_ack_i), .s1_resp_i(s1_resp_i), .s1_rdata_bi(s1_rdata_bi),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic master(input logic req, input logic we, input logic [31:0] addr);
    m_req_i   = req;
    m_we_i    = we;
    m_addr_bi = addr;
  endtask

  initial begin
    rst_i = 1'b1;
    master(1'b0, 1'b0, 32'h0);
    m_be_bi = 4'hF; m_wdata_bi = 32'h0;
    s0_ack_i = 1'b0; s0_resp_i = 1'b0; s0_rdata_bi = 32'h0;
    s1_ack_i = 1'b0; s1_resp_i = 1'b0; s1_rdata_bi = 32'h0;
    tick(); tick();
    chk("rst_outstanding", 32'(outstanding_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_resp", 32'(m_resp_o), 32'd0);
    chk("rst_rdata", m_rdata_bo, 32'd0);
    rst_i = 1'b0;
    tick();

    // Write to S0 with combinational ack.
    master(1'b1, 1'b1, 32'h0000_0000);
    m_wdata_bi = 32'h0000_A5A5; s0_ack_i = 1'b1;
    #1;
    chk("wr_s0_req", 32'(s0_req_o), 32'd1);
    chk("wr_s0_addr", s0_addr_bo, 32'h0);
    chk("wr_s0_wdata", s0_wdata_bo, 32'h0000_A5A5);
    chk("wr_s0_we", 32'(s0_we_o), 32'd1);
    chk("wr_m_ack", 32'(m_ack_o), 32'd1);
    chk("wr_s1_req", 32'(s1_req_o), 32'd0);
    tick();
    master(1'b0, 1'b0, 32'h0); s0_ack_i = 1'b0;
    chk("wr_no_resp", 32'(m_resp_o), 32'd0);
    chk("wr_no_track", 32'(outstanding_o), 32'd0);

    // Read S1 at 0x80000010 with a 2-cycle response latency.
    master(1'b1, 1'b0, 32'h8000_0010); s1_ack_i = 1'b1;
    #1;
    chk("rd_s1_ack", 32'(m_ack_o), 32'd1);
    chk("rd_s1_addr", s1_addr_bo, 32'h10);
    chk("rd_s1_s0req", 32'(s0_req_o), 32'd0);
    tick();
    master(1'b0, 1'b0, 32'h0); s1_ack_i = 1'b0;
    chk("rd_s1_outst", 32'(outstanding_o), 32'd1);
    tick();
    s1_resp_i = 1'b1; s1_rdata_bi = 32'h1234_5678;
    chk("rd_s1_not_yet", 32'(m_resp_o), 32'd0);
    tick();
    s1_resp_i = 1'b0;
    chk("rd_s1_resp", 32'(m_resp_o), 32'd1);
    chk("rd_s1_data", m_rdata_bo, 32'h1234_5678);
    chk("rd_s1_popped", 32'(outstanding_o), 32'd0);
    tick();
    chk("rd_s1_resp_end", 32'(m_resp_o), 32'd0);
    chk("rd_s1_data_hold", m_rdata_bo, 32'h1234_5678);

    // Unmapped read completes locally two cycles after acceptance.
    master(1'b1, 1'b0, 32'h4000_0000);
    #1;
    chk("unm_ack", 32'(m_ack_o), 32'd1);
    chk("unm_s0_req", 32'(s0_req_o), 32'd0);
    chk("unm_s1_req", 32'(s1_req_o), 32'd0);
    tick();
    master(1'b0, 1'b0, 32'h0);
    chk("unm_resp_early", 32'(m_resp_o), 32'd0);
    tick();
    chk("unm_resp", 32'(m_resp_o), 32'd1);
    chk("unm_data", m_rdata_bo, 32'hDEAD_BEEF);
    chk("unm_outst", 32'(outstanding_o), 32'd0);

    // S1 read then S0 read: S0 waits for the S1 response to drain.
    master(1'b1, 1'b0, 32'h8000_0020); s1_ack_i = 1'b1;
    tick();
    master(1'b1, 1'b0, 32'h0000_0004); s1_ack_i = 1'b0; s0_ack_i = 1'b1;
    #1;
    chk("ord_stall_ack", 32'(m_ack_o), 32'd0);
    chk("ord_stall_s0req", 32'(s0_req_o), 32'd0);
    tick(); tick(); tick();
    chk("ord_still_stall", 32'(m_ack_o), 32'd0);
    s1_resp_i = 1'b1; s1_rdata_bi = 32'h1111_1111;
    #1;
    chk("ord_stall_at_resp", 32'(m_ack_o), 32'd0);
    tick();
    s1_resp_i = 1'b0;
    chk("ord_resp1", 32'(m_resp_o), 32'd1);
    chk("ord_data1", m_rdata_bo, 32'h1111_1111);
    chk("ord_s0_ack", 32'(m_ack_o), 32'd1);
    chk("ord_s0_req", 32'(s0_req_o), 32'd1);
    tick();
    master(1'b0, 1'b0, 32'h0); s0_ack_i = 1'b0;
    s0_resp_i = 1'b1; s0_rdata_bi = 32'h2222_2222;
    chk("ord_outst", 32'(outstanding_o), 32'd1);
    tick();
    s0_resp_i = 1'b0;
    chk("ord_resp2", 32'(m_resp_o), 32'd1);
    chk("ord_data2", m_rdata_bo, 32'h2222_2222);
    chk("ord_no_err", 32'(err_o), 32'd0);

    // Stray S0 response with an empty tracker.
    s0_resp_i = 1'b1; s0_rdata_bi = 32'h5555_5555;
    tick();
    s0_resp_i = 1'b0;
    chk("err_set", 32'(err_o), 32'd1);
    chk("err_no_resp", 32'(m_resp_o), 32'd0);
    tick();
    chk("err_sticky", 32'(err_o), 32'd1);
    chk("err_data_hold", m_rdata_bo, 32'h2222_2222);

    // Five back-to-back S1 reads with S1 silent: tracker fills at four.
    s1_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      master(1'b1, 1'b0, 32'h8000_0000 + 32'(i * 4));
      #1;
      chk($sformatf("burst_ack%0d", i), 32'(m_ack_o), 32'd1);
      tick();
    end
    master(1'b1, 1'b0, 32'h8000_0010);
    #1;
    chk("burst_full", 32'(outstanding_o), 32'd4);
    chk("burst_stall_ack", 32'(m_ack_o), 32'd0);
    chk("burst_stall_req", 32'(s1_req_o), 32'd0);
    tick();
    s1_resp_i = 1'b1; s1_rdata_bi = 32'h3333_3333;
    #1;
    chk("burst_stall_resp_cyc", 32'(m_ack_o), 32'd0);
    tick();
    s1_resp_i = 1'b0;
    chk("burst_after_pop", 32'(outstanding_o), 32'd3);
    chk("burst_5th_ack", 32'(m_ack_o), 32'd1);
    chk("burst_resp_data", m_rdata_bo, 32'h3333_3333);
    tick();
    master(1'b0, 1'b0, 32'h0); s1_ack_i = 1'b0;
    chk("burst_refill", 32'(outstanding_o), 32'd4);

    // Asynchronous reset mid-burst, away from any clock edge.
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_outst", 32'(outstanding_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_rdata", m_rdata_bo, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    s1_resp_i = 1'b1; s1_rdata_bi = 32'h4444_4444;
    tick();
    s1_resp_i = 1'b0;
    chk("late_resp_err", 32'(err_o), 32'd1);
    chk("late_resp_drop", 32'(m_resp_o), 32'd0);
    chk("late_resp_outst", 32'(outstanding_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
